alu_arbiter: RTL and testbench

- Shares the single registered 72-bit ALU between two requesters: port 0 is the execute stage and port 1 is the branch/compare unit.
- Uses round-robin arbitration and valid/ready handshakes on both the request and response side.
- Drives the ALU op/A/B inputs, holds them stable for the required cycles, captures C, and returns it to the winning requester.
- Only one operation is in flight at a time.

---
 rtl/alu_arbiter_if.sv | 34 +++
 rtl/alu_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bus between the two ALU requesters and
// alu_arbiter.
//   req{0,1}_valid/ready/op/a/b : request handshake plus operands
//   resp{0,1}_valid/ready        : response handshake, one per requester
//   resp_data                    : captured ALU result, shared by both ports
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int WIDTH = 72,
  parameter int OP_W  = 4
);
  logic             req0_valid, req0_ready;
  logic [OP_W-1:0]  req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [OP_W-1:0]  req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             resp0_valid, resp0_ready;
  logic             resp1_valid, resp1_ready;
  logic [WIDTH-1:0] resp_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between the execute stage (port 0)
// and the branch/compare unit (port 1). Round-robin grant, one op in flight.
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : request/response handshakes and resp_data
//   alu_op/alu_a/alu_b  : registered ALU inputs, held for the whole op
//   alu_c               : ALU result, registered by the ALU one edge later
//   busy                : controller is not IDLE
// Optional: define ALU_ARBITER_STATS_EN to add stats_clr and the saturating
// grant_cnt0/grant_cnt1 grant counters.
module alu_arbiter #(
  parameter int WIDTH      = 72,
  parameter int OP_W       = 4,
  parameter int MULDIV_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c,
  output logic             busy
`ifdef ALU_ARBITER_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  req_t             alu_q, alu_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic [1:0]       resp_vld_q, resp_vld_d;

  logic [1:0] req_vld, resp_rdy, gnt, hs;
  req_t       req [2];
  logic       sel, muldiv;

  assign req_vld  = {bus.req1_valid, bus.req0_valid};
  assign resp_rdy = {bus.resp1_ready, bus.resp0_ready};
  assign req[0]   = {bus.req0_op, bus.req0_a, bus.req0_b};
  assign req[1]   = {bus.req1_op, bus.req1_a, bus.req1_b};

  // Round-robin: on contention the port that did not win last time goes.
  always_comb begin
    gnt = req_vld;
    if (&req_vld) gnt = last_grant_q ? 2'b01 : 2'b10;
  end

  // Ready is gated by rst_n so it drops with the rest of the outputs
  // while reset is held, even if a requester keeps valid high.
  assign hs     = (state_q == IDLE && rst_n) ? gnt : 2'b00;
  assign sel    = hs[1];
  assign muldiv = (req[sel].op == OP_W'(2)) || (req[sel].op == OP_W'(3));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    wait_d       = wait_q;
    alu_d        = alu_q;
    resp_data_d  = resp_data_q;
    resp_vld_d   = resp_vld_q;
    case (state_q)
      IDLE: if (|hs) begin
        alu_d        = req[sel];
        last_grant_d = sel;
        owner_d      = sel;
        wait_d       = muldiv ? CNT_W'(MULDIV_LAT) : '0;
        state_d      = EXEC;
      end
      // ALU samples the held inputs every edge; extra cycles only for mul/div.
      EXEC: if (wait_q != '0) wait_d = wait_q - CNT_W'(1);
            else              state_d = CAPT;
      CAPT: begin
        resp_data_d          = alu_c;
        resp_vld_d[owner_q]  = 1'b1;
        state_d              = RESP;
      end
      RESP: if (|(resp_vld_q & resp_rdy)) begin
        resp_vld_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      wait_q       <= '0;
      alu_q        <= '0;
      resp_data_q  <= '0;
      resp_vld_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      wait_q       <= wait_d;
      alu_q        <= alu_d;
      resp_data_q  <= resp_data_d;
      resp_vld_q   <= resp_vld_d;
    end
  end

  assign bus.req0_ready  = hs[0];
  assign bus.req1_ready  = hs[1];
  assign bus.resp0_valid = resp_vld_q[0];
  assign bus.resp1_valid = resp_vld_q[1];
  assign bus.resp_data   = resp_data_q;
  assign alu_op          = alu_q.op;
  assign alu_a           = alu_q.a;
  assign alu_b           = alu_q.b;
  assign busy            = (state_q != IDLE);

`ifdef ALU_ARBITER_STATS_EN
  logic [1:0][15:0] gcnt_q, gcnt_d;

  // Clear has priority over a coincident grant; counts saturate.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      gcnt_d[i] = gcnt_q[i];
      if (stats_clr)                             gcnt_d[i] = '0;
      else if (hs[i] && gcnt_q[i] != 16'hFFFF)   gcnt_d[i] = gcnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gcnt_q <= '0;
    else        gcnt_q <= gcnt_d;
  end

  assign grant_cnt0 = gcnt_q[0];
  assign grant_cnt1 = gcnt_q[1];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed steps then a randomized
// phase checked against a "last served port" round-robin model and a
// behavioural ALU.
module tb_alu_arbiter;
  localparam int W   = 72;
  localparam int OW  = 4;
  localparam int LAT = 2;

  logic          clk, rst_n;
  logic [OW-1:0] alu_op;
  logic [W-1:0]  alu_a, alu_b, alu_c;
  logic          busy;
`ifdef ALU_ARBITER_STATS_EN
  logic          stats_clr;
  logic [15:0]   grant_cnt0, grant_cnt1;
  bit            clr_at_grant;
`endif

  int checks = 0;
  int errors = 0;
  bit model_last;

  alu_arbiter_if #(.WIDTH(W), .OP_W(OW)) bus ();

  alu_arbiter #(.WIDTH(W), .OP_W(OW), .MULDIV_LAT(LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .alu_op (alu_op),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_c  (alu_c),
    .busy   (busy)
`ifdef ALU_ARBITER_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [OW-1:0] op,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == '0) ? '1 : a / b;
      4'd12:   return W'(a == b);
      default: return a ^ b;
    endcase
  endfunction

  // Registered ALU: C follows the inputs sampled at the previous edge.
  always @(posedge clk) alu_c <= alu_fn(alu_op, alu_a, alu_b);

  function automatic logic [W-1:0] rnd72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // Reference arbitration: contention goes to the port not served last.
  function automatic bit pick(input bit v0, input bit v1);
    if (v0 && v1) return !model_last;
    return !v0;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rdy_vec();
    return W'({bus.req1_ready, bus.req0_ready});
  endfunction

  function automatic logic [W-1:0] rsp_vec();
    return W'({bus.resp1_valid, bus.resp0_valid});
  endfunction

  // One full transaction. Starts anywhere in an IDLE cycle away from the
  // rising edge and returns just after the response handshake edge, so a
  // following call lands in the very next cycle.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [OW-1:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [OW-1:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input bit exp_p, input logic [W-1:0] exp_d, input int hold);
    logic [OW-1:0] eop;
    logic [W-1:0]  ea, eb, exp_rdy;
    int            lat;
    eop     = exp_p ? op1 : op0;
    ea      = exp_p ? a1 : a0;
    eb      = exp_p ? b1 : b0;
    lat     = 3 + ((eop == 4'd2 || eop == 4'd3) ? LAT : 0);
    exp_rdy = exp_p ? W'(2'b10) : W'(2'b01);
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
`ifdef ALU_ARBITER_STATS_EN
    stats_clr = clr_at_grant;
`endif
    #1;
    chk("idle_busy", W'(busy), W'(0));
    chk("grant_ready", rdy_vec(), exp_rdy);
    @(posedge clk); #1;
`ifdef ALU_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    model_last = exp_p;
    // Scramble the request side; the controller must not look at it.
    bus.req0_valid = 1'b1; bus.req0_op = 4'($urandom); bus.req0_a = rnd72(); bus.req0_b = rnd72();
    bus.req1_valid = 1'b1; bus.req1_op = 4'($urandom); bus.req1_a = rnd72(); bus.req1_b = rnd72();
    chk("alu_op", W'(alu_op), W'(eop));
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    chk("busy_exec", W'(busy), W'(1));
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      chk("resp_early", rsp_vec(), W'(0));
      chk("busy_ready", rdy_vec(), W'(0));
      chk("alu_hold", {W'(alu_op) ^ alu_a, alu_b} == {W'(eop) ^ ea, eb} ? W'(1) : W'(0), W'(1));
    end
    @(negedge clk);
    chk("resp_valid", rsp_vec(), exp_rdy);
    chk("resp_data", bus.resp_data, exp_d);
    // The other port's ready must not complete this response.
    if (exp_p) bus.resp0_ready = 1'b1; else bus.resp1_ready = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_vec(), exp_rdy);
      chk("hold_data", bus.resp_data, exp_d);
      chk("hold_ready", rdy_vec(), W'(0));
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    if (exp_p) bus.resp1_ready = 1'b1; else bus.resp0_ready = 1'b1;
    @(posedge clk); #1;
    chk("resp_cleared", rsp_vec(), W'(0));
    chk("busy_done", W'(busy), W'(0));
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
  endtask

  initial begin
    bit v0, v1, p;
    logic [OW-1:0] o0, o1;
    logic [W-1:0] ra0, rb0, ra1, rb1;

    // Reset with both requesters pushing: everything must read zero.
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 4'd1; bus.req0_a = 72'd1; bus.req0_b = 72'd1;
    bus.req1_valid = 1'b1; bus.req1_op = 4'd1; bus.req1_a = 72'd1; bus.req1_b = 72'd1;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
`ifdef ALU_ARBITER_STATS_EN
    stats_clr = 1'b0; clr_at_grant = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ready", rdy_vec(), W'(0));
    chk("rst_resp", rsp_vec(), W'(0));
    chk("rst_data", bus.resp_data, W'(0));
    chk("rst_alu", {W'(alu_op), alu_a} | {W'(0), alu_b}, {W'(0), W'(0)});
    chk("rst_busy", W'(busy), W'(0));
`ifdef ALU_ARBITER_STATS_EN
    chk("rst_cnt", W'({grant_cnt1, grant_cnt0}), W'(0));
`endif
    rst_n = 1'b1; model_last = 1'b1;

    // Single add from port 0.
    run_txn(1, 0, 4'd0, 72'd5, 72'd7, 4'd0, 72'd0, 72'd0, 0, 72'd12, 0);

    // Fresh reset, then three contended requests: 0, 1, 0.
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; model_last = 1'b1;
    run_txn(1, 1, 4'd1, 72'd10, 72'd3, 4'd12, 72'd4, 72'd4, 0, 72'd7, 0);
    run_txn(1, 1, 4'd1, 72'd10, 72'd3, 4'd12, 72'd4, 72'd4, 1, 72'd1, 0);
    run_txn(1, 1, 4'd0, 72'd1, 72'd2, 4'd12, 72'd4, 72'd5, 0, 72'd3, 0);

    // Multiply from port 1 takes MULDIV_LAT extra cycles.
    run_txn(0, 1, 4'd0, 72'd0, 72'd0, 4'd2, 72'd6, 72'd7, 1, 72'd42, 0);

    // Response back-pressure, then port 1 accepted the next cycle.
    run_txn(1, 0, 4'd0, 72'd8, 72'd8, 4'd0, 72'd0, 72'd0, 0, 72'd16, 4);
    run_txn(0, 1, 4'd0, 72'd0, 72'd0, 4'd1, 72'd9, 72'd2, 1, 72'd7, 0);

    // Full-width operands pass through untruncated.
    run_txn(1, 0, 4'd15, {72{1'b1}}, 72'h80_0000_0000_0000_0001, 4'd0, 72'd0, 72'd0,
            0, 72'h7F_FFFF_FFFF_FFFF_FFFE, 0);

    // Reset during EXEC of a divide aborts it; port 0 then wins contention.
    bus.req0_valid = 1'b1; bus.req0_op = 4'd3; bus.req0_a = 72'd100; bus.req0_b = 72'd5;
    bus.req1_valid = 1'b0;
    #1;
    chk("div_ready", rdy_vec(), W'(2'b01));
    @(posedge clk); #1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    chk("div_busy", W'(busy), W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_alu", {W'(alu_op), alu_a} | {W'(0), alu_b}, {W'(0), W'(0)});
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_ready", rdy_vec(), W'(0));
    chk("abort_data", bus.resp_data, W'(0));
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp", rsp_vec(), W'(0));
    end
    rst_n = 1'b1; model_last = 1'b1;
    run_txn(1, 1, 4'd0, 72'd9, 72'd4, 4'd1, 72'd9, 72'd4, 0, 72'd13, 0);

    // Randomized phase against the reference model.
    for (int n = 0; n < 40; n++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      o0 = 4'($urandom_range(0, 15)); o1 = 4'($urandom_range(0, 15));
      ra0 = rnd72(); rb0 = rnd72(); ra1 = rnd72(); rb1 = rnd72();
      if ($urandom_range(0, 3) == 0) rb0 = {64'd0, 8'($urandom)};
      p = pick(v0, v1);
      run_txn(v0, v1, o0, ra0, rb0, o1, ra1, rb1, p,
              p ? alu_fn(o1, ra1, rb1) : alu_fn(o0, ra0, rb0), $urandom_range(0, 3));
    end

`ifdef ALU_ARBITER_STATS_EN
    stats_clr = 1'b1; @(posedge clk); #1; stats_clr = 1'b0;
    chk("stats_clr", W'({grant_cnt1, grant_cnt0}), W'(0));
    repeat (3) run_txn(1, 0, 4'd0, 72'd1, 72'd1, 4'd0, 72'd0, 72'd0, 0, 72'd2, 0);
    run_txn(0, 1, 4'd0, 72'd0, 72'd0, 4'd0, 72'd2, 72'd2, 1, 72'd4, 0);
    chk("stats_cnt0", W'(grant_cnt0), W'(3));
    chk("stats_cnt1", W'(grant_cnt1), W'(1));
    clr_at_grant = 1'b1;
    run_txn(1, 0, 4'd0, 72'd1, 72'd1, 4'd0, 72'd0, 72'd0, 0, 72'd2, 0);
    clr_at_grant = 1'b0;
    chk("stats_clr_wins", W'({grant_cnt1, grant_cnt0}), W'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
